inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Small instruction FIFO directly downstream of the PC register and instruction fetch path, upstream of decode.
- Buffers {pc, inst} pairs produced by fetch.
- Asserts a stall back to the PC register when full, so the PC holds.
- Discards all buffered entries on pipeline flush (exception or ertn redirect).

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, 32, PC width.
- DATA_W, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  pipeline flush; clears the queue.
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}.
- in_pc  input  ADDR_W  PC of the fetched instruction.
- in_inst  input  DATA_W  fetched instruction word.
- in_ready  output  1  queue can accept a push this cycle.
- stall_o  output  1  hold request to the PC register; high when full.
- out_valid  output  1  head entry valid toward decode.
- out_pc  output  ADDR_W  head entry PC.
- out_inst  output  DATA_W  head entry instruction.
- out_ready  input  1  decode accepts the head this cycle.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: DEPTH entries of {pc, inst}, plus a write pointer and a read pointer, each $clog2(DEPTH) bits.
- Pointers wrap modulo DEPTH. The count register tracks occupancy in the range 0..DEPTH.
- Asynchronous reset (rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: out_valid=0, out_pc=0, out_inst=0, in_ready=1, stall_o=0, count_o=0.
  - Entry storage need not be cleared.
  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Combinational output flags:
  - in_ready = (count != DEPTH).
  - stall_o = (count == DEPTH).
  - out_valid = (count != 0).
- Head data:
  - out_pc/out_inst = storage[rd_ptr] when out_valid=1.
  - Forced to 0 when the queue is empty.
- Push: storage[wr_ptr] <= {in_pc, in_inst}; wr_ptr <= wr_ptr+1.
- Pop: rd_ptr <= rd_ptr+1.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when push and pop happen together.
- Latency: a pushed entry becomes visible on out_* the cycle after the push (one-cycle latency), unless the bypass option below is compiled in.
- Full with pop in the same cycle: in_ready=0, so no push. The entry count drops to DEPTH-1, and stall_o deasserts next cycle.
- Empty with push in the same cycle: out_valid=0, so no pop. The count becomes 1.
- Flush (synchronous):
  - wr_ptr, rd_ptr and count go to 0 at the next edge.
  - Flush overrides any push or pop in the same cycle; neither takes effect.
  - The cycle after a flush: out_valid=0, in_ready=1, stall_o=0.
- in_valid while in_ready=0: the input is ignored. Fetch must keep holding it, which it does because stall_o holds the PC.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- When defined:
  - If count==0 and in_valid=1, then out_valid=1 and out_pc/out_inst = in_pc/in_inst combinationally.
  - If out_ready=1 in that cycle, the entry passes straight through without being stored; pointers and count are unchanged.
  - If out_ready=0, the entry is stored as a normal push.
  - Flush suppresses the bypass: out_valid=0 during a flush cycle while empty.
- When not defined: one-cycle latency exactly as described in Behaviour.

Test Plan:
- Reset: assert rst mid-cycle with count=2 → out_valid=0, count_o=0 and in_ready=1 immediately; out_pc=0.
- Fill with out_ready=0: push pc=0x1c000000,0x1c000004,0x1c000008,0x1c00000c → count_o=4, stall_o=1, in_ready=0. A fifth in_valid is ignored and count_o stays 4.
- Simultaneous at full:
  - Stimulus: full queue, out_ready=1, in_valid=1.
  - Head pc=0x1c000000 pops and no push occurs; next cycle count_o=3 and stall_o=0.
  - Next cycle, push plus pop together leaves count_o=3.
- Wrap-around: stream 10 entries with pc=0x1c000000+4k, with out_ready toggling every cycle → decode receives all 10 in order, no loss or duplication, through at least two pointer wraps.
- Flush: flush=1 with count=3 in the same cycle as in_valid=1 and out_ready=1 → next cycle count_o=0, out_valid=0, and the pushed entry is absent.
- Bypass, with IFQ_BYPASS_EN defined:
  - Empty queue, in_valid=1, in_pc=0x1c000020, out_ready=1 → same cycle out_valid=1 and out_pc=0x1c000020; count_o stays 0.
  - Without the macro: out_valid=0 that cycle and 1 the next.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Purpose:
//   Small instruction FIFO between the fetch stage and the decode stage.
//   It buffers {pc, inst} pairs from fetch. When full, it raises a stall so the
//   PC register holds. A pipeline flush (exception or ertn redirect) drops every
//   buffered entry.
//
// Optional feature (compile-time macro IFQ_BYPASS_EN):
//   When defined, an instruction that arrives while the queue is empty is shown
//   to decode in the same cycle. If decode takes it in that cycle, the entry
//   passes straight through and is never stored.
//
// Parameters:
//   DEPTH   number of entries (power of two, >= 2)
//   ADDR_W  PC width
//   DATA_W  instruction width
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous pipeline flush; empties the queue
//   in_valid   fetch presents {in_pc, in_inst}
//   in_pc      PC of the fetched instruction
//   in_inst    fetched instruction word
//   in_ready   queue accepts a push this cycle
//   stall_o    hold request to the PC register (queue full)
//   out_valid  head entry valid toward decode
//   out_pc     head entry PC (0 when empty)
//   out_inst   head entry instruction (0 when empty)
//   out_ready  decode accepts the head this cycle
//   count_o    number of occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [DATA_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     stall_o,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage is not reset; validity comes only from r_count.
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_inst_mem [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_store;
    logic              w_release;
    logic [CNT_W-1:0]  w_count_d;

    // -------------------------------------------------------------------------
    // Occupancy flags and bypass qualification
    // -------------------------------------------------------------------------
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == FULL_CNT);
`ifdef IFQ_BYPASS_EN
        // A flush cycle must not leak a redirected-away instruction to decode.
        w_bypass = w_empty & in_valid & ~flush;
`else
        w_bypass = 1'b0;
`endif
    end

    // -------------------------------------------------------------------------
    // Outputs toward fetch and decode
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = ~w_full;
        stall_o   = w_full;
        out_valid = ~w_empty | w_bypass;
        count_o   = r_count;
        out_pc    = '0;
        out_inst  = '0;
        if (!w_empty) begin
            out_pc   = r_pc_mem[r_rd_ptr];
            out_inst = r_inst_mem[r_rd_ptr];
        end else if (w_bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end
    end

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    always_comb begin
        w_push = in_valid & in_ready;
        w_pop  = out_valid & out_ready;
        // A bypassed entry that decode consumes right away never touches storage.
        // When the queue is empty, a pop can only be of the bypassed entry, so it
        // never advances the read side.
        w_store   = w_push & ~(w_bypass & out_ready);
        w_release = w_pop & ~w_bypass;
    end

    always_comb begin
        w_count_d = r_count;
        case ({w_store, w_release})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    // -------------------------------------------------------------------------
    // Pointer and count state; flush has priority over push and pop
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the natural overflow wraps modulo DEPTH.
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_release) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_store) begin
            r_pc_mem[r_wr_ptr]   <= in_pc;
            r_inst_mem[r_wr_ptr] <= in_inst;
        end
    end

endmodule
